// File: rtl/fme_input_sequencer.sv
// Streams one 8x8 block's reference and original rows from line memories into the
// fractional motion estimation core, with a registered read-data stage and busy/done handshake.
module fme_input_sequencer #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned REF_ROWS  = 16,
  parameter int unsigned ORG_ROWS  = 8,
  parameter int unsigned ORG_DELAY = 5,
  parameter int unsigned ADDRW     = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRW-1:0]        base_ref_addr,
  input  logic [ADDRW-1:0]        base_org_addr,
  input  logic [DATAWIDTH+8:0]    best_sad_ime_in,
  output logic                    ref_rd_en,
  output logic [ADDRW-1:0]        ref_rd_addr,
  input  logic [16*DATAWIDTH-1:0] ref_rd_data,
  output logic                    org_rd_en,
  output logic [ADDRW-1:0]        org_rd_addr,
  input  logic [8*DATAWIDTH-1:0]  org_rd_data,
  output logic                    enable,
  output logic [DATAWIDTH-1:0]    in_0,
  output logic [DATAWIDTH-1:0]    in_1,
  output logic [DATAWIDTH-1:0]    in_2,
  output logic [DATAWIDTH-1:0]    in_3,
  output logic [DATAWIDTH-1:0]    in_4,
  output logic [DATAWIDTH-1:0]    in_5,
  output logic [DATAWIDTH-1:0]    in_6,
  output logic [DATAWIDTH-1:0]    in_7,
  output logic [DATAWIDTH-1:0]    in_8,
  output logic [DATAWIDTH-1:0]    in_9,
  output logic [DATAWIDTH-1:0]    in_10,
  output logic [DATAWIDTH-1:0]    in_11,
  output logic [DATAWIDTH-1:0]    in_12,
  output logic [DATAWIDTH-1:0]    in_13,
  output logic [DATAWIDTH-1:0]    in_14,
  output logic [DATAWIDTH-1:0]    in_15,
  output logic [DATAWIDTH-1:0]    original_0,
  output logic [DATAWIDTH-1:0]    original_1,
  output logic [DATAWIDTH-1:0]    original_2,
  output logic [DATAWIDTH-1:0]    original_3,
  output logic [DATAWIDTH-1:0]    original_4,
  output logic [DATAWIDTH-1:0]    original_5,
  output logic [DATAWIDTH-1:0]    original_6,
  output logic [DATAWIDTH-1:0]    original_7,
  output logic [DATAWIDTH+8:0]    best_sad_ime,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned OrgEnd  = ORG_DELAY + ORG_ROWS;
  localparam int unsigned LastCyc = ((REF_ROWS > OrgEnd) ? REF_ROWS : OrgEnd) + 1;
  localparam int unsigned CycW    = $clog2(LastCyc + 1);

  localparam logic [CycW-1:0] RefEndC   = CycW'(REF_ROWS);
  localparam logic [CycW-1:0] OrgBeginC = CycW'(ORG_DELAY);
  localparam logic [CycW-1:0] OrgEndC   = CycW'(OrgEnd);
  localparam logic [CycW-1:0] LastC     = CycW'(LastCyc);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CycW-1:0]           cyc_q;
  logic [ADDRW-1:0]          base_ref_q, base_org_q;
  logic [DATAWIDTH+8:0]      sad_q;
  logic                      ref_v_q, org_v_q, enable_q;
  logic [16*DATAWIDTH-1:0]   ref_row_q;
  logic [8*DATAWIDTH-1:0]    org_row_q;

  always_comb begin
    state_d     = state_q;
    ref_rd_en   = 1'b0;
    org_rd_en   = 1'b0;
    ref_rd_addr = '0;
    org_rd_addr = '0;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        ref_rd_en = (cyc_q < RefEndC);
        org_rd_en = (cyc_q >= OrgBeginC) && (cyc_q < OrgEndC);
        if (cyc_q == LastC) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Addresses are forced to zero outside their read windows.
    if (ref_rd_en) ref_rd_addr = base_ref_q + ADDRW'(cyc_q);
    if (org_rd_en) org_rd_addr = base_org_q + ADDRW'(cyc_q) - ADDRW'(ORG_DELAY);
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      base_ref_q <= '0;
      base_org_q <= '0;
      sad_q      <= '0;
      ref_v_q    <= 1'b0;
      org_v_q    <= 1'b0;
      enable_q   <= 1'b0;
      ref_row_q  <= '0;
      org_row_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        cyc_q      <= '0;
        base_ref_q <= base_ref_addr;
        base_org_q <= base_org_addr;
        sad_q      <= best_sad_ime_in;
      end else if (state_q == StRun) begin
        cyc_q <= cyc_q + 1'b1;
      end
      // Read issued in cycle c returns in c+1 and is presented in c+2.
      ref_v_q   <= ref_rd_en;
      org_v_q   <= org_rd_en;
      enable_q  <= ref_v_q;
      ref_row_q <= ref_v_q ? ref_rd_data : '0;
      org_row_q <= org_v_q ? org_rd_data : '0;
    end
  end

  assign enable       = enable_q;
  assign best_sad_ime = sad_q;

  assign in_0  = ref_row_q[0*DATAWIDTH +: DATAWIDTH];
  assign in_1  = ref_row_q[1*DATAWIDTH +: DATAWIDTH];
  assign in_2  = ref_row_q[2*DATAWIDTH +: DATAWIDTH];
  assign in_3  = ref_row_q[3*DATAWIDTH +: DATAWIDTH];
  assign in_4  = ref_row_q[4*DATAWIDTH +: DATAWIDTH];
  assign in_5  = ref_row_q[5*DATAWIDTH +: DATAWIDTH];
  assign in_6  = ref_row_q[6*DATAWIDTH +: DATAWIDTH];
  assign in_7  = ref_row_q[7*DATAWIDTH +: DATAWIDTH];
  assign in_8  = ref_row_q[8*DATAWIDTH +: DATAWIDTH];
  assign in_9  = ref_row_q[9*DATAWIDTH +: DATAWIDTH];
  assign in_10 = ref_row_q[10*DATAWIDTH +: DATAWIDTH];
  assign in_11 = ref_row_q[11*DATAWIDTH +: DATAWIDTH];
  assign in_12 = ref_row_q[12*DATAWIDTH +: DATAWIDTH];
  assign in_13 = ref_row_q[13*DATAWIDTH +: DATAWIDTH];
  assign in_14 = ref_row_q[14*DATAWIDTH +: DATAWIDTH];
  assign in_15 = ref_row_q[15*DATAWIDTH +: DATAWIDTH];

  assign original_0 = org_row_q[0*DATAWIDTH +: DATAWIDTH];
  assign original_1 = org_row_q[1*DATAWIDTH +: DATAWIDTH];
  assign original_2 = org_row_q[2*DATAWIDTH +: DATAWIDTH];
  assign original_3 = org_row_q[3*DATAWIDTH +: DATAWIDTH];
  assign original_4 = org_row_q[4*DATAWIDTH +: DATAWIDTH];
  assign original_5 = org_row_q[5*DATAWIDTH +: DATAWIDTH];
  assign original_6 = org_row_q[6*DATAWIDTH +: DATAWIDTH];
  assign original_7 = org_row_q[7*DATAWIDTH +: DATAWIDTH];

endmodule

// File: tb/tb_fme_input_sequencer.sv
// Directed bench for fme_input_sequencer: line memories modelled with 1-cycle read latency,
// expectations computed from the row/pixel fill patterns.
module tb_fme_input_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   base_ref_addr, base_org_addr;
  logic [16:0]  best_sad_ime_in;
  logic         ref_rd_en, org_rd_en, enable, busy, done;
  logic [7:0]   ref_rd_addr, org_rd_addr;
  logic [127:0] ref_rd_data;
  logic [63:0]  org_rd_data;
  logic [7:0]   in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7;
  logic [7:0]   in_8, in_9, in_10, in_11, in_12, in_13, in_14, in_15;
  logic [7:0]   original_0, original_1, original_2, original_3;
  logic [7:0]   original_4, original_5, original_6, original_7;
  logic [16:0]  best_sad_ime;

  logic [127:0] ref_mem [256];
  logic [63:0]  org_mem [256];

  int checks = 0;
  int errors = 0;

  fme_input_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .base_ref_addr(base_ref_addr), .base_org_addr(base_org_addr),
    .best_sad_ime_in(best_sad_ime_in),
    .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
    .org_rd_en(org_rd_en), .org_rd_addr(org_rd_addr), .org_rd_data(org_rd_data),
    .enable(enable),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .in_4(in_4), .in_5(in_5), .in_6(in_6), .in_7(in_7),
    .in_8(in_8), .in_9(in_9), .in_10(in_10), .in_11(in_11),
    .in_12(in_12), .in_13(in_13), .in_14(in_14), .in_15(in_15),
    .original_0(original_0), .original_1(original_1), .original_2(original_2),
    .original_3(original_3), .original_4(original_4), .original_5(original_5),
    .original_6(original_6), .original_7(original_7),
    .best_sad_ime(best_sad_ime), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Garbage on the bus when not reading, so ungated data would show up.
  always @(posedge clock) begin
    ref_rd_data <= ref_rd_en ? ref_mem[ref_rd_addr] : {16{8'hA5}};
    org_rd_data <= org_rd_en ? org_mem[org_rd_addr] : {8{8'h5A}};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One block from IDLE with full per-cycle checks; optional start pulses during RUN and DONE.
  task automatic run_block(input logic [7:0] bref, input logic [16:0] sad);
    int exp_in0, exp_org0;
    bit en_exp, org_exp;
    base_ref_addr   = bref;
    base_org_addr   = 8'h00;
    best_sad_ime_in = sad;
    start           = 1'b1;
    step();
    start           = 1'b0;
    best_sad_ime_in = ~sad;
    for (int c = 0; c <= 19; c++) begin
      en_exp   = (c >= 2) && (c <= 17);
      org_exp  = (c >= 7) && (c <= 14);
      exp_in0  = en_exp ? ((((int'(bref) + c - 2) & 255) * 16) & 255) : 0;
      exp_org0 = org_exp ? (8'h80 + (c - 7) * 8) : 0;
      chk($sformatf("ref_rd_en c%0d", c), 32'(ref_rd_en), 32'(c < 16));
      chk($sformatf("ref_rd_addr c%0d", c), 32'(ref_rd_addr),
          (c < 16) ? 32'((int'(bref) + c) & 255) : 32'd0);
      chk($sformatf("org_rd_en c%0d", c), 32'(org_rd_en), 32'((c >= 5) && (c < 13)));
      chk($sformatf("org_rd_addr c%0d", c), 32'(org_rd_addr),
          ((c >= 5) && (c < 13)) ? 32'(c - 5) : 32'd0);
      chk($sformatf("enable c%0d", c), 32'(enable), 32'(en_exp));
      chk($sformatf("in_0 c%0d", c), 32'(in_0), 32'(exp_in0));
      chk($sformatf("in_15 c%0d", c), 32'(in_15), en_exp ? 32'(exp_in0 + 15) : 32'd0);
      chk($sformatf("original_0 c%0d", c), 32'(original_0), 32'(exp_org0));
      chk($sformatf("original_7 c%0d", c), 32'(original_7), org_exp ? 32'(exp_org0 + 7) : 32'd0);
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(c <= 18));
      chk($sformatf("done c%0d", c), 32'(done), 32'(c == 18));
      chk($sformatf("best_sad c%0d", c), 32'(best_sad_ime), 32'(sad));
      start = (c == 10) || (c == 18);
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    int done_seen;
    int k;
    for (int a = 0; a < 256; a++) begin
      for (int p = 0; p < 16; p++) ref_mem[a][p*8 +: 8] = 8'((a * 16 + p) & 255);
      for (int p = 0; p < 8; p++)  org_mem[a][p*8 +: 8] = 8'((8'h80 + a * 8 + p) & 255);
    end
    reset = 1'b1; start = 1'b0;
    base_ref_addr = 8'h00; base_org_addr = 8'h00; best_sad_ime_in = 17'h1FFFF;
    step(); step();
    chk("rst enable", 32'(enable), 0);
    chk("rst ref_rd_en", 32'(ref_rd_en), 0);
    chk("rst ref_rd_addr", 32'(ref_rd_addr), 0);
    chk("rst org_rd_en", 32'(org_rd_en), 0);
    chk("rst in_0", 32'(in_0), 0);
    chk("rst best_sad", 32'(best_sad_ime), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    reset = 1'b0;
    step();

    // Basic block, SAD latch, and start pulses during RUN/DONE ignored.
    run_block(8'h00, 17'h1ABCD);
    chk("idle after block", 32'(busy), 0);

    // Continuous start: blocks recur every 20 cycles with enable low across DONE.
    best_sad_ime_in = 17'h0F0F0;
    start = 1'b1;
    for (int i = 0; i <= 45; i++) begin
      k = (i - 1) % 20;
      chk($sformatf("b2b enable i%0d", i), 32'(enable), 32'((i >= 1) && (k >= 2) && (k <= 17)));
      chk($sformatf("b2b done i%0d", i), 32'(done), 32'((i >= 1) && (k == 18)));
      chk($sformatf("b2b busy i%0d", i), 32'(busy), 32'((i >= 1) && (k <= 18)));
      step();
    end
    chk("b2b best_sad", 32'(best_sad_ime), 32'h0F0F0);
    start = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      step();
      k++;
    end
    chk("b2b drain", 32'(busy), 0);
    step();

    // Reference address wrap.
    run_block(8'hF8, 17'h00042);

    // Reset in RUN cycle 9 aborts immediately.
    base_ref_addr = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 9; c++) step();
    chk("pre-abort enable", 32'(enable), 1);
    reset = 1'b1;
    #1;
    chk("abort enable", 32'(enable), 0);
    chk("abort ref_rd_en", 32'(ref_rd_en), 0);
    chk("abort ref_rd_addr", 32'(ref_rd_addr), 0);
    chk("abort org_rd_en", 32'(org_rd_en), 0);
    chk("abort org_rd_addr", 32'(org_rd_addr), 0);
    chk("abort in_0", 32'(in_0), 0);
    chk("abort in_15", 32'(in_15), 0);
    chk("abort original_0", 32'(original_0), 0);
    chk("abort best_sad", 32'(best_sad_ime), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    step();
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy || enable) done_seen++;
      step();
    end
    chk("no done after abort", 32'(done_seen), 0);
    run_block(8'h00, 17'h12345);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
